// File: rtl/dec_nx_bist.sv
// dec_nx_bist
// Registered one-hot decoder with a built-in self-test sweep.
//
// Normal operation (IDLE) decodes sel into a one-hot d when en is high.
// After a bist_start pulse, every code from 0 to 2**N-1 is swept through
// the same decode core and output register. Each registered result is
// compared against the expected one-hot value. The first failing code is
// latched, and later failures do not replace it.
//
// Optional feature macro: DEC_FAULT_INJ_EN. When it is defined, a
// fault_mask port is added. The mask is XORed onto the core output ahead
// of the d register in every mode, so test code can plant decode faults.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   en              functional decode enable (IDLE only)
//   sel   [N-1:0]   functional select code (IDLE only)
//   fault_mask      [2**N-1:0] XOR mask on core output (DEC_FAULT_INJ_EN only)
//   d     [2**N-1:0] registered one-hot output
//   bist_start      self-test request, one cycle, honoured in IDLE only
//   bist_busy       high in SWEEP and DRAIN (2**N+1 cycles)
//   bist_done       one-cycle pulse in DONE
//   bist_pass       result of last self-test, held until next start
//   bist_fail_code  first failing code of last self-test, else 0
//   dbg_state [1:0] current FSM state (IDLE=0, SWEEP=1, DRAIN=2, DONE=3)
//
// Handshake: bist_start is a single-cycle request and needs no ready. It is
// accepted only in IDLE and ignored in every other state. Completion is
// signalled by the single-cycle bist_done pulse. bist_pass and
// bist_fail_code are valid from that pulse until the next accepted start.
module dec_nx_bist #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [N-1:0]        sel,
`ifdef DEC_FAULT_INJ_EN
    input  logic [(2**N)-1:0]   fault_mask,
`endif
    output logic [(2**N)-1:0]   d,
    input  logic                bist_start,
    output logic                bist_busy,
    output logic                bist_done,
    output logic                bist_pass,
    output logic [N-1:0]        bist_fail_code,
    output logic [1:0]          dbg_state
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   d_q, d_d;
    logic           pass_q, pass_d;
    logic [N-1:0]   code_q, code_d;
    logic           fail_seen_q, fail_seen_d;
    // Checker pipeline: the code that was driven into the core last cycle
    // and whether the value now sitting in d_q belongs to the sweep.
    logic           chk_valid_q, chk_valid_d;
    logic [N-1:0]   exp_code_q, exp_code_d;

    logic           core_en;
    logic [N-1:0]   core_sel;
    logic [W-1:0]   core_out;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        code_d      = code_q;
        fail_seen_d = fail_seen_q;
        chk_valid_d = (state_q == SWEEP);
        exp_code_d  = cnt_q;
        core_en     = 1'b0;
        core_sel    = sel;

        case (state_q)
            IDLE: begin
                core_en  = en;
                core_sel = sel;
                if (bist_start) begin
                    // The self-test takes priority over en. Code 0 is driven
                    // right away, so d shows code 0 on the next edge.
                    state_d     = SWEEP;
                    cnt_d       = '0;
                    core_en     = 1'b1;
                    core_sel    = '0;
                    pass_d      = 1'b1;
                    code_d      = '0;
                    fail_seen_d = 1'b0;
                end
            end
            SWEEP: begin
                core_en  = 1'b1;
                core_sel = cnt_q;
                if (cnt_q == N'(W - 1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first mismatch is sticky. Later ones leave the result alone.
        if (chk_valid_q && !fail_seen_q && (d_q != (W'(1) << exp_code_q))) begin
            pass_d      = 1'b0;
            code_d      = exp_code_q;
            fail_seen_d = 1'b1;
        end

        core_out = core_en ? (W'(1) << core_sel) : '0;
`ifdef DEC_FAULT_INJ_EN
        d_d = core_out ^ fault_mask;
`else
        d_d = core_out;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            d_q         <= '0;
            pass_q      <= 1'b0;
            code_q      <= '0;
            fail_seen_q <= 1'b0;
            chk_valid_q <= 1'b0;
            exp_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            pass_q      <= pass_d;
            code_q      <= code_d;
            fail_seen_q <= fail_seen_d;
            chk_valid_q <= chk_valid_d;
            exp_code_q  <= exp_code_d;
        end
    end

    assign d              = d_q;
    assign bist_busy      = (state_q == SWEEP) || (state_q == DRAIN);
    assign bist_done      = (state_q == DONE);
    assign bist_pass      = pass_q;
    assign bist_fail_code = code_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dec_nx_bist.sv
module tb_dec_nx_bist;

  localparam int N = 4;
  localparam int W = 1 << N;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] sel;
  logic [W-1:0] fault_mask;
  logic [W-1:0] d;
  logic         bist_start;
  logic         bist_busy;
  logic         bist_done;
  logic         bist_pass;
  logic [N-1:0] bist_fail_code;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  dec_nx_bist #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .sel            (sel),
`ifdef DEC_FAULT_INJ_EN
    .fault_mask     (fault_mask),
`endif
    .d              (d),
    .bist_start     (bist_start),
    .bist_busy      (bist_busy),
    .bist_done      (bist_done),
    .bist_pass      (bist_pass),
    .bist_fail_code (bist_fail_code),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return to the falling edge. Inputs change there
  // and outputs are sampled there.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sel = 4'd7; bist_start = 1'b1; fault_mask = '0;
    step();
    step();
    checks++;
    if (d !== '0 || bist_busy !== 1'b0 || bist_done !== 1'b0 ||
        bist_pass !== 1'b0 || bist_fail_code !== '0) begin
      errors++;
      $display("FAIL reset: d=%h busy=%b done=%b pass=%b code=%h, expected all zero",
               d, bist_busy, bist_done, bist_pass, bist_fail_code);
    end
    rst = 1'b0; en = 1'b0; bist_start = 1'b0;
    step();
  endtask

  // Directed en=1/sel=5 and en=0 steps, followed by a random run checked
  // against a one-cycle queue.
  task automatic test_functional();
    logic [W-1:0] exp;
    en = 1'b1; sel = 4'd5;
    step();
    checks++;
    if (d !== 16'h0020) begin
      errors++; $display("FAIL func_sel5: d=%h expected 0020", d);
    end
    en = 1'b0;
    step();
    checks++;
    if (d !== 16'h0000) begin
      errors++; $display("FAIL func_en0: d=%h expected 0000", d);
    end
    for (int i = 0; i < 40; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      sel = N'($urandom_range(0, W - 1));
      exp_q.push_back(en ? (W'(1) << sel) : W'(0));
      step();
      exp = exp_q.pop_front();
      checks++;
      if (d !== exp) begin
        errors++; $display("FAIL func_rand[%0d]: d=%h expected %h", i, d, exp);
      end
    end
    en = 1'b0;
    step();
  endtask

  // Runs one self-test and checks the busy window, the d walk, the done
  // pulse and the result. The model: busy cycle k shows code max(k-2,0),
  // the DRAIN cycle shows code W-1, and the expected failure is the lowest
  // code whose observed value differs from its one-hot.
  task automatic run_sweep(input string tag, input logic [W-1:0] mask,
                           input bit noise, input bit start_with_en);
    int           busy_cnt;
    int           code;
    logic [W-1:0] exp;
    bit           exp_pass;
    logic [N-1:0] exp_code;
    fault_mask = mask;
    exp_pass = 1'b1;
    exp_code = '0;
    for (int c = 0; c < W; c++) begin
      if (exp_pass && ((((W'(1) << c)) ^ mask) != (W'(1) << c))) begin
        exp_pass = 1'b0;
        exp_code = N'(c);
      end
    end
    bist_start = 1'b1;
    if (start_with_en) begin
      en = 1'b1; sel = 4'd9;
    end
    step();
    bist_start = 1'b0;
    en = 1'b0;
    busy_cnt = 0;
    while (bist_busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      code = (busy_cnt < 2) ? 0 : busy_cnt - 2;
      if (code > W - 1) code = W - 1;
      exp = (W'(1) << code) ^ mask;
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL %s walk[%0d]: d=%h expected %h", tag, busy_cnt, d, exp);
      end
      if (bist_done === 1'b1) begin
        errors++;
        $display("FAIL %s done_during_busy[%0d]: done=1 expected 0", tag, busy_cnt);
      end
      if (noise) begin
        bist_start = 1'($urandom_range(0, 1));
        en = 1'b1;
        sel = 4'd3;
      end
      step();
    end
    bist_start = 1'b0;
    en = 1'b0;
    checks++;
    if (busy_cnt !== W + 1) begin
      errors++; $display("FAIL %s busy_len: %0d expected %0d", tag, busy_cnt, W + 1);
    end
    checks++;
    if (bist_done !== 1'b1 || d !== mask) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b d=%h expected done=1 d=%h", tag, bist_done, d, mask);
    end
    checks++;
    if (bist_pass !== exp_pass || bist_fail_code !== exp_code) begin
      errors++;
      $display("FAIL %s result: pass=%b code=%h expected pass=%b code=%h",
               tag, bist_pass, bist_fail_code, exp_pass, exp_code);
    end
    step();
    checks++;
    if (bist_done !== 1'b0 || bist_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b expected 0 0", tag, bist_done, bist_busy);
    end
    // The result must hold through later functional traffic.
    for (int i = 0; i < 5; i++) begin
      en = 1'($urandom_range(0, 1));
      sel = N'($urandom_range(0, W - 1));
      step();
    end
    en = 1'b0;
    checks++;
    if (bist_pass !== exp_pass || bist_fail_code !== exp_code) begin
      errors++;
      $display("FAIL %s result_hold: pass=%b code=%h expected pass=%b code=%h",
               tag, bist_pass, bist_fail_code, exp_pass, exp_code);
    end
    fault_mask = '0;
    step();
  endtask

  task automatic test_bist_clean();
    run_sweep("bist_clean", '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep("bist_noise", '0, 1'b1, 1'b0);
  endtask

  task automatic test_start_with_en();
    run_sweep("bist_start_en", '0, 1'b0, 1'b1);
  endtask

  task automatic test_fault_inj();
`ifdef DEC_FAULT_INJ_EN
    run_sweep("bist_fault", 16'h0400, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_abort();
    int  busy_cnt;
    bit  saw_done;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    busy_cnt = 0;
    while (bist_busy === 1'b1 && busy_cnt < 6) begin
      busy_cnt++;
      if (busy_cnt < 6) step();
    end
    checks++;
    if (busy_cnt !== 6) begin
      errors++; $display("FAIL abort_busy_reach: %0d expected 6", busy_cnt);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bist_busy !== 1'b0 || bist_pass !== 1'b0 || d !== '0 || bist_fail_code !== '0) begin
      errors++;
      $display("FAIL abort_state: busy=%b pass=%b d=%h code=%h expected 0 0 0000 0",
               bist_busy, bist_pass, d, bist_fail_code);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bist_done === 1'b1 || bist_busy === 1'b1) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: activity=%b expected 0", saw_done);
    end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_bist_clean();
    test_back_to_back();
    test_start_with_en();
    test_fault_inj();
    test_abort();
    test_functional();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
